timer_seq_ctrl: RTL and testbench
=================================

Name: timer_seq_ctrl

Overview:
- Complete serial-programmed countdown timer built around the start-sequence/shift/count/wait control flow.
- Searches the serial `data` stream for a start pattern, then shifts in a DELAY_W-bit delay value, MSB first.
- Counts for (delay+1)*TICKS cycles while showing the remaining count, then raises `done` until `ack`.
- Contains its own delay shift register, prescaler and down-counter; no external datapath is needed.

Parameters:
- PATTERN, 4'b1101, start pattern; the last-received bit is the LSB.
- PATTERN_W, 4, pattern length in bits.
- DELAY_W, 4, width of the delay field and of `count`.
- TICKS, 1000, clock cycles per count step; legal range >= 2. Prescaler width is $clog2(TICKS).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  1  serial input stream, sampled every cycle.
- ack  input  1  acknowledge that releases `done`.
- count  output  DELAY_W  remaining delay value during counting, 0 otherwise.
- counting  output  1  high while the timer is counting.
- done  output  1  high while waiting for `ack`.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset:
  - state=SEARCH; history=0; seen=0; delay=0; prescaler=0; shift counter=0.
  - count=0, counting=0, done=0.
  - Reset has priority over every other event, including mid-SHIFT and mid-COUNT.
- States: SEARCH, SHIFT, COUNT, WAIT. All outputs are Moore (registered state only).
- SEARCH:
  - Each cycle, history <= {history[PATTERN_W-2:0], data}.
  - `seen` saturates at PATTERN_W.
  - Match condition: {history[PATTERN_W-2:0], data} == PATTERN, and at least PATTERN_W-1 bits were already seen in this SEARCH visit.
  - Detection is overlapping: 1,1,1,0,1 matches on the 5th bit.
  - On match, next state is SHIFT and the shift counter clears.
- SHIFT:
  - Lasts exactly DELAY_W cycles.
  - Each cycle, delay <= {delay[DELAY_W-2:0], data}.
  - After the DELAY_W-th bit, next state is COUNT with prescaler=0.
  - `data` is ignored outside SEARCH and SHIFT.
- COUNT:
  - counting=1; count=delay; prescaler increments every cycle.
  - When prescaler==TICKS-1:
    - if delay==0, next state is WAIT;
    - else delay decrements and prescaler returns to 0.
  - counting is therefore high for exactly (delay+1)*TICKS consecutive cycles.
  - count shows delay, delay-1, ..., 0; each value is held TICKS cycles.
- WAIT:
  - done=1, count=0.
  - ack=1 at a clock edge moves to SEARCH with history and seen cleared.
  - `data` in the ack cycle is not used for pattern search.
  - The first bit searched is the one sampled in the cycle after the edge that leaves WAIT.
- `ack` is ignored in every state except WAIT. ack held high on WAIT entry releases after one cycle of done.
- Latency: first delay bit is sampled in the cycle after the last pattern bit. counting rises the cycle after the last delay bit.
- No wrap-around: the down-counter never decrements below 0.

Optional Feature:
- Macro: TIMER_SEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit), listed after `ack`.
  - abort=1 at an edge while in SHIFT or COUNT returns to SEARCH, with history, seen, delay and prescaler cleared.
  - done is never asserted for an aborted run. abort is ignored in SEARCH and WAIT.
- Undefined: no `abort` port; behaviour as above.

Test Plan:
- TICKS=4. Send data 1,1,0,1 then 0,1,0,1 (delay=5) -> counting high 24 cycles; count = 5,4,3,2,1,0, each for 4 cycles; done=1 the next cycle.
- TICKS=4. Send data 1,1,1,0,1 then 0,0,0,0 -> overlapping match detected; counting high 4 cycles with count=0; then done=1.
- In WAIT, hold ack=0 for 10 cycles -> done stays 1. Pulse ack with data=1 in the same cycle, then send 1,0,1,x -> no match on the 1,1,0,1 formed with the ack-cycle bit; SEARCH restarts clean.
- Assert reset for one cycle mid-COUNT (count=3) -> next cycle count=0, counting=0, done=0. A subsequent full sequence times normally.
- Default TICKS=1000, delay=1 -> counting high exactly 2000 cycles; count=1 for 1000 cycles, then 0 for 1000 cycles.
- With TIMER_SEQ_ABORT_EN defined, pulse abort in the 2nd SHIFT cycle and separately mid-COUNT -> returns to SEARCH; done never rises; the next pattern is accepted.

Source files
------------

// File: rtl/timer_seq_ctrl.sv
// Serial-programmed countdown timer: finds a start pattern, shifts in a delay, counts (delay+1)*TICKS cycles, then holds done until ack.
// Optional abort input is enabled by defining TIMER_SEQ_ABORT_EN.
module timer_seq_ctrl #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter int                   DELAY_W   = 4,
  parameter int                   TICKS     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
`ifdef TIMER_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int SW = $clog2(PATTERN_W + 1);
  localparam int CW = $clog2(DELAY_W + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(TICKS - 1);
  localparam logic [SW-1:0] SEEN_MAX = SW'(PATTERN_W);
  localparam logic [SW-1:0] SEEN_MIN = SW'(PATTERN_W - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(DELAY_W - 1);

  typedef enum logic [1:0] {SEARCH, SHIFT, COUNT, WAIT} state_t;

  state_t               state, state_next;
  logic [PATTERN_W-1:0] history, history_next, shifted;
  logic [SW-1:0]        seen, seen_next;
  logic [DELAY_W-1:0]   delay, delay_next;
  logic [PW-1:0]        prescaler, prescaler_next;
  logic [CW-1:0]        shift_cnt, shift_cnt_next;

  assign shifted = {history[PATTERN_W-2:0], data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      history   <= '0;
      seen      <= '0;
      delay     <= '0;
      prescaler <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_next;
      history   <= history_next;
      seen      <= seen_next;
      delay     <= delay_next;
      prescaler <= prescaler_next;
      shift_cnt <= shift_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    history_next   = history;
    seen_next      = seen;
    delay_next     = delay;
    prescaler_next = prescaler;
    shift_cnt_next = shift_cnt;
    case (state)
      SEARCH: begin
        history_next = shifted;
        if (seen != SEEN_MAX) seen_next = seen + 1'b1;
        // seen counts bits before this one, so the match needs PATTERN_W-1 already in
        if (shifted == PATTERN && seen >= SEEN_MIN) begin
          state_next     = SHIFT;
          shift_cnt_next = '0;
        end
      end
      SHIFT: begin
        delay_next     = {delay[DELAY_W-2:0], data};
        shift_cnt_next = shift_cnt + 1'b1;
        if (shift_cnt == SHIFT_LAST) begin
          state_next     = COUNT;
          prescaler_next = '0;
        end
      end
      COUNT: begin
        if (prescaler == PS_LAST) begin
          if (delay == '0) begin
            state_next = WAIT;
          end else begin
            delay_next     = delay - 1'b1;
            prescaler_next = '0;
          end
        end else begin
          prescaler_next = prescaler + 1'b1;
        end
      end
      WAIT: begin
        if (ack) begin
          state_next   = SEARCH;
          history_next = '0;
          seen_next    = '0;
        end
      end
      default: state_next = SEARCH;
    endcase
`ifdef TIMER_SEQ_ABORT_EN
    if (abort && (state == SHIFT || state == COUNT)) begin
      state_next     = SEARCH;
      history_next   = '0;
      seen_next      = '0;
      delay_next     = '0;
      prescaler_next = '0;
    end
`endif
  end

  assign counting = (state == COUNT);
  assign done     = (state == WAIT);
  assign count    = counting ? delay : '0;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: a TICKS=4 instance and a default TICKS=1000 instance share stimulus and are checked each cycle against a timeline model.
module tb_timer_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, data, ack, abort;
  logic [3:0] count0, count1;
  logic       counting0, counting1, done0, done1;

  int checks = 0;
  int errors = 0;

  timer_seq_ctrl #(.TICKS(4)) dut0 (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
`ifdef TIMER_SEQ_ABORT_EN
    .abort(abort),
`endif
    .count(count0), .counting(counting0), .done(done0)
  );

  timer_seq_ctrl dut1 (
    .clk(clk), .reset(reset), .data(data), .ack(ack),
`ifdef TIMER_SEQ_ABORT_EN
    .abort(abort),
`endif
    .count(count1), .counting(counting1), .done(done1)
  );

  always #5 clk = ~clk;

  // Model: phase 0 search, 1 shift, 2 count, 3 wait; count derived from elapsed cycles
  int  mt[2] = '{4, 1000};
  int  ph[2], hv[2], hn[2], val[2], nb[2], el[2];
  bit  mvalid = 1'b0;

  int  run[2], ones[2], last_run[2], last_ones[2], first_cnt[2];
  bit  saw[2];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        ph[i] = 0; hv[i] = 0; hn[i] = 0; val[i] = 0; nb[i] = 0; el[i] = 0;
      end else begin
        case (ph[i])
          0: begin
            hv[i] = ((hv[i] << 1) | int'(data)) & 15;
            hn[i]++;
            if (hn[i] >= 4 && hv[i] == 13) begin
              ph[i] = 1; nb[i] = 0; val[i] = 0;
            end
          end
          1: begin
            if (abort) begin
              ph[i] = 0; hv[i] = 0; hn[i] = 0;
            end else begin
              val[i] = val[i] * 2 + int'(data);
              nb[i]++;
              if (nb[i] == 4) begin ph[i] = 2; el[i] = 0; end
            end
          end
          2: begin
            if (abort) begin
              ph[i] = 0; hv[i] = 0; hn[i] = 0;
            end else begin
              el[i]++;
              if (el[i] == (val[i] + 1) * mt[i]) ph[i] = 3;
            end
          end
          default: begin
            if (ack) begin ph[i] = 0; hv[i] = 0; hn[i] = 0; end
          end
        endcase
      end
    end
    if (reset) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        int dc, dcn, dd;
        dc  = (i == 0) ? int'(count0)    : int'(count1);
        dcn = (i == 0) ? int'(counting0) : int'(counting1);
        dd  = (i == 0) ? int'(done0)     : int'(done1);
        checkOutput($sformatf("counting[%0d]", i), dcn, (ph[i] == 2) ? 1 : 0);
        checkOutput($sformatf("count[%0d]", i), dc, (ph[i] == 2) ? val[i] - el[i] / mt[i] : 0);
        checkOutput($sformatf("done[%0d]", i), dd, (ph[i] == 3) ? 1 : 0);
        if (dcn != 0) begin
          if (run[i] == 0) first_cnt[i] = dc;
          run[i]++;
          if (dc == 1) ones[i]++;
          saw[i] = 1'b1;
        end else if (run[i] > 0) begin
          last_run[i]  = run[i];
          last_ones[i] = ones[i];
          run[i] = 0;
          ones[i] = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic d, input logic a, input logic r, input logic ab);
    @(posedge clk);
    #1;
    data = d; ack = a; reset = r; abort = ab;
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) applyStimulus(bits[k], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitDone(input int idx, input int limit);
    int k;
    k = 0;
    while (k < limit && ((idx == 0) ? done0 : done1) !== 1'b1) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    checkOutput($sformatf("wait_done[%0d]", idx), int'((idx == 0) ? done0 : done1), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    data = 0; ack = 0; reset = 1; abort = 0;
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("reset_count0", int'(count0), 0);
    checkOutput("reset_counting0", int'(counting0), 0);
    checkOutput("reset_done0", int'(done0), 0);
    checkOutput("reset_counting1", int'(counting1), 0);

    // delay=5 -> 24 counting cycles starting at count 5
    sendBits(16'b1101_0101, 8);
    waitDone(0, 100);
    checkOutput("t1_run", last_run[0], 24);
    checkOutput("t1_first", first_cnt[0], 5);
    checkOutput("t1_done", int'(done0), 1);

    // overlapping pattern 1,1,1,0,1 with delay 0
    applyStimulus(0, 1, 0, 0);
    sendBits(16'b1_1101_0000, 9);
    waitDone(0, 100);
    checkOutput("t2_run", last_run[0], 4);
    checkOutput("t2_first", first_cnt[0], 0);

    // done holds without ack; the ack-cycle bit must not seed the search
    repeat (10) applyStimulus(0, 0, 0, 0);
    checkOutput("t3_hold_done", int'(done0), 1);
    applyStimulus(1, 1, 0, 0);
    saw[0] = 1'b0;
    sendBits(16'b1010, 4);
    repeat (12) applyStimulus(0, 0, 0, 0);
    checkOutput("t3_no_match", int'(saw[0]), 0);
    checkOutput("t3_left_wait", int'(done0), 0);
    sendBits(16'b1101_0010, 8);
    waitDone(0, 100);
    checkOutput("t3_run", last_run[0], 12);

    // reset mid-count at count=3, then a normal run
    applyStimulus(0, 1, 0, 0);
    sendBits(16'b1101_0011, 8);
    begin
      int k;
      k = 0;
      while (k < 50 && !(counting0 === 1'b1 && count0 == 4'd3)) begin
        applyStimulus(0, 0, 0, 0);
        k++;
      end
      checkOutput("t4_reach_3", int'(count0), 3);
    end
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_count", int'(count0), 0);
    checkOutput("t4_counting", int'(counting0), 0);
    checkOutput("t4_done", int'(done0), 0);
    sendBits(16'b1101_0001, 8);
    waitDone(0, 100);
    checkOutput("t4_run", last_run[0], 8);

`ifdef TIMER_SEQ_ABORT_EN
    // abort during the second shift cycle
    applyStimulus(0, 1, 0, 0);
    sendBits(16'b1101_0, 5);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    saw[0] = 1'b0;
    repeat (10) applyStimulus(0, 0, 0, 0);
    checkOutput("ab1_no_count", int'(saw[0]), 0);
    checkOutput("ab1_done", int'(done0), 0);
    sendBits(16'b1101_0000, 8);
    waitDone(0, 100);
    checkOutput("ab1_run", last_run[0], 4);

    // abort mid-count
    applyStimulus(0, 1, 0, 0);
    sendBits(16'b1101_0010, 8);
    repeat (4) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ab2_counting", int'(counting0), 0);
    repeat (10) applyStimulus(0, 0, 0, 0);
    checkOutput("ab2_done", int'(done0), 0);
    sendBits(16'b1101_0000, 8);
    waitDone(0, 100);
    checkOutput("ab2_run", last_run[0], 4);
`endif

    // default TICKS=1000 with delay=1
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    sendBits(16'b1101_0001, 8);
    waitDone(1, 2200);
    checkOutput("t5_run", last_run[1], 2000);
    checkOutput("t5_ones", last_ones[1], 1000);
    checkOutput("t5_first", first_cnt[1], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
